// File: rtl/cpu_wb_pkg.sv
// Shared types and helpers for the register-file write-back path.
package cpu_wb_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/wb_pend_fifo.sv
// Buffer for long-latency register writes: per-entry valid bits, kill-by-address
// and pending-match lookup for the decode-stage read ports.
module wb_pend_fifo
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          kill,
  input  logic [AW-1:0] kill_addr,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          full,
  output logic          empty,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic          pend1,
  output logic          pend2
);
  localparam int PW = clog2(DEPTH);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_d;
  logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_en, pop_en;

  assign full       = (cnt_q == (PW+1)'(DEPTH));
  assign empty      = (cnt_q == '0);
  assign push_en    = push && !full;
  assign pop_en     = pop && !empty;
  assign head_valid = ent_q[rp_q].valid;
  assign head_addr  = ent_q[rp_q].addr;
  assign head_data  = ent_q[rp_q].data;

  always_comb begin
    ent_d = ent_q;
    // Kill sees only entries already stored; a same-cycle push lands afterwards.
    for (int i = 0; i < DEPTH; i++)
      if (kill && ent_q[i].valid && ent_q[i].addr == kill_addr) ent_d[i].valid = 1'b0;
    if (pop_en) ent_d[rp_q].valid = 1'b0;
    if (push_en) ent_d[wp_q] = '{valid: 1'b1, addr: push_addr, data: push_data};
    wp_d  = wp_q + PW'(push_en);
    rp_d  = rp_q + PW'(pop_en);
    cnt_d = cnt_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
  end

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].addr == rd_addr1) pend1 = 1'b1;
      if (ent_q[i].valid && ent_q[i].addr == rd_addr2) pend2 = 1'b1;
    end
    if (rd_addr1 == '0) pend1 = 1'b0;
    if (rd_addr2 == '0) pend2 = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges WB-stage writes (priority, never stall) with buffered long-latency writes
// onto the RegFile write port. Optional macro WB_FWD_EN forwards data3 to q1/q2.
module regfile_wb_arbiter
  import cpu_wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_wr,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_data,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          pend1,
  output logic          pend2,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic [DW-1:0] q1,
  output logic [DW-1:0] q2,
  output logic          wr,
  output logic [AW-1:0] addr3,
  output logic [DW-1:0] data3
);
  logic          prim, pop, full, empty, head_valid;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr3_q, addr3_d;
  logic [DW-1:0] data3_q, data3_d;

  assign prim    = p_wr && (p_addr != '0);
  assign pop     = !prim && !empty;
  assign s_ready = !full;

  // s_addr==0 completes the handshake but never occupies a slot.
  wb_pend_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s_valid && s_addr != '0),
    .push_addr (s_addr),
    .push_data (s_data),
    .pop       (pop),
    .kill      (prim),
    .kill_addr (p_addr),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .full      (full),
    .empty     (empty),
    .head_valid(head_valid),
    .head_addr (head_addr),
    .head_data (head_data),
    .pend1     (pend1),
    .pend2     (pend2)
  );

  always_comb begin
    wr_d    = 1'b0;
    addr3_d = addr3_q;
    data3_d = data3_q;
    if (prim) begin
      wr_d    = 1'b1;
      addr3_d = p_addr;
      data3_d = p_data;
    end else if (pop && head_valid) begin
      wr_d    = 1'b1;
      addr3_d = head_addr;
      data3_d = head_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      addr3_q <= '0;
      data3_q <= '0;
    end else begin
      wr_q    <= wr_d;
      addr3_q <= addr3_d;
      data3_q <= data3_d;
    end
  end

  assign wr    = wr_q;
  assign addr3 = addr3_q;
  assign data3 = data3_q;

`ifdef WB_FWD_EN
  assign q1 = (wr_q && addr3_q == rd_addr1 && rd_addr1 != '0) ? data3_q : rf_data1;
  assign q2 = (wr_q && addr3_q == rd_addr2 && rd_addr2 != '0) ? data3_q : rf_data2;
`else
  assign q1 = rf_data1;
  assign q2 = rf_data2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed checks of regfile_wb_arbiter against a queue-based model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 0, reset = 0;
  logic        p_wr = 0, s_valid = 0;
  logic [4:0]  p_addr = 0, s_addr = 0, rd_addr1 = 0, rd_addr2 = 0;
  logic [31:0] p_data = 0, s_data = 0, rf_data1 = 0, rf_data2 = 0;
  logic        s_ready, pend1, pend2, wr;
  logic [4:0]  addr3;
  logic [31:0] q1, q2, data3;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset), .p_wr(p_wr), .p_addr(p_addr), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend1(pend1), .pend2(pend2),
    .rf_data1(rf_data1), .rf_data2(rf_data2), .q1(q1), .q2(q2),
    .wr(wr), .addr3(addr3), .data3(data3)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; logic [4:0] a; logic [31:0] d;} mdl_t;
  mdl_t        m_q[$];
  bit          e_wr;
  logic [4:0]  e_a;
  logic [31:0] e_d;
  logic [31:0] rf [32];
  bit          last_acc;
  int          n_cmp = 0, n_bad = 0;

`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic bit m_pend(input logic [4:0] a);
    if (a == 0) return 1'b0;
    foreach (m_q[i]) if (m_q[i].v && m_q[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: check comb outputs mid-cycle, advance model, check registered outputs.
  task automatic cycle();
    mdl_t h;
    bit acc;
    logic [31:0] x1, x2;
    #1;
    x1 = (FWD && e_wr && e_a == rd_addr1 && rd_addr1 != 0) ? e_d : rf_data1;
    x2 = (FWD && e_wr && e_a == rd_addr2 && rd_addr2 != 0) ? e_d : rf_data2;
    n_cmp++; if (s_ready !== (m_q.size() < DEPTH)) begin n_bad++; $display("FAIL s_ready got %b want %b t=%0t", s_ready, m_q.size() < DEPTH, $time); end
    n_cmp++; if (pend1 !== m_pend(rd_addr1)) begin n_bad++; $display("FAIL pend1 got %b want %b t=%0t", pend1, m_pend(rd_addr1), $time); end
    n_cmp++; if (pend2 !== m_pend(rd_addr2)) begin n_bad++; $display("FAIL pend2 got %b want %b t=%0t", pend2, m_pend(rd_addr2), $time); end
    n_cmp++; if (q1 !== x1) begin n_bad++; $display("FAIL q1 got %h want %h t=%0t", q1, x1, $time); end
    n_cmp++; if (q2 !== x2) begin n_bad++; $display("FAIL q2 got %h want %h t=%0t", q2, x2, $time); end
    acc = s_valid && (m_q.size() < DEPTH);
    if (p_wr && p_addr != 0) begin
      foreach (m_q[i]) if (m_q[i].a == p_addr) m_q[i].v = 1'b0;
      e_wr = 1; e_a = p_addr; e_d = p_data;
    end else if (m_q.size() > 0) begin
      h = m_q.pop_front();
      e_wr = h.v;
      if (h.v) begin e_a = h.a; e_d = h.d; end
    end else e_wr = 0;
    if (acc && s_addr != 0) m_q.push_back('{1'b1, s_addr, s_data});
    last_acc = acc;
    @(posedge clk); #1;
    n_cmp++; if (wr !== e_wr) begin n_bad++; $display("FAIL wr got %b want %b t=%0t", wr, e_wr, $time); end
    if (e_wr) begin
      n_cmp++; if (addr3 !== e_a || data3 !== e_d) begin n_bad++; $display("FAIL wdata got %0d/%h want %0d/%h t=%0t", addr3, data3, e_a, e_d, $time); end
    end
    if (wr) rf[addr3] = data3;
  endtask

  task automatic idle(input int n);
    p_wr = 0; s_valid = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic test_reset();
    reset = 0; #1;
    n_cmp++; if (wr !== 0 || addr3 !== 0 || data3 !== 0) begin n_bad++; $display("FAIL reset_out got %b/%0d/%h want 0/0/0", wr, addr3, data3); end
    n_cmp++; if (s_ready !== 1 || pend1 !== 0 || pend2 !== 0) begin n_bad++; $display("FAIL reset_flags got %b%b%b want 100", s_ready, pend1, pend2); end
    e_wr = 0; e_a = 0; e_d = 0; m_q.delete();
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_secondary();
    rd_addr1 = 8; rd_addr2 = 0;
    p_wr = 0; s_valid = 1; s_addr = 8; s_data = 32'h1234;
    cycle();
    idle(4);
  endtask

  task automatic test_priority_full();
    int k, acc6, cyc;
    k = 0; acc6 = 0; cyc = 0;
    rd_addr1 = 9; rd_addr2 = 12;
    while ((k < 5 || m_q.size() > 0) && cyc < 40) begin
      p_wr = (cyc < 6); p_addr = 2; p_data = 32'h200 + cyc;
      s_valid = (k < 5); s_addr = 5'(9 + k); s_data = 32'h900 + k;
      cycle();
      if (last_acc) begin k++; if (cyc < 6) acc6++; end
      cyc++;
    end
    n_cmp++; if (acc6 !== 4) begin n_bad++; $display("FAIL full_accepts got %0d want 4", acc6); end
    n_cmp++; if (rf[13] !== 32'h904) begin n_bad++; $display("FAIL reg13 got %h want 904", rf[13]); end
    idle(2);
  endtask

  task automatic test_kill();
    rd_addr1 = 5; rd_addr2 = 3;
    p_wr = 1; p_addr = 3; p_data = 32'h3;
    s_valid = 1; s_addr = 5; s_data = 32'hAAAA;
    cycle();
    s_valid = 0; p_addr = 5; p_data = 32'hBBBB;
    cycle();
    idle(4);
    n_cmp++; if (rf[5] !== 32'hBBBB) begin n_bad++; $display("FAIL kill_reg5 got %h want bbbb", rf[5]); end
    p_wr = 1; p_addr = 5; p_data = 32'hDDDD;
    s_valid = 1; s_addr = 5; s_data = 32'hCCCC;
    cycle();
    idle(4);
    n_cmp++; if (rf[5] !== 32'hCCCC) begin n_bad++; $display("FAIL young_reg5 got %h want cccc", rf[5]); end
  endtask

  task automatic test_zero();
    rd_addr1 = 0; rd_addr2 = 0;
    for (int i = 0; i < 6; i++) begin
      p_wr = 1; p_addr = 0; p_data = $urandom;
      s_valid = 1; s_addr = 0; s_data = $urandom;
      cycle();
      n_cmp++; if (!last_acc || s_ready !== 1) begin n_bad++; $display("FAIL zero_handshake got %b want 1", s_ready); end
    end
    idle(2);
  endtask

  task automatic test_fwd();
    p_wr = 1; p_addr = 7; p_data = 32'hCAFE; s_valid = 0;
    cycle();
    p_wr = 0; rd_addr1 = 7; rf_data1 = 0; rd_addr2 = 0; rf_data2 = 32'h55;
    cycle();
    n_cmp++; if (q1 !== 32'h0) begin n_bad++; $display("FAIL fwd_after got %h want 0", q1); end
    rf_data1 = 0;
  endtask

  task automatic test_reset_midstream();
    rd_addr1 = 20; rd_addr2 = 21;
    for (int i = 0; i < 3; i++) begin
      p_wr = 1; p_addr = 1; p_data = i;
      s_valid = 1; s_addr = 5'(20 + i); s_data = 32'hF0 + i;
      cycle();
    end
    p_wr = 0; s_valid = 0;
    #3 reset = 0; #1;
    n_cmp++; if (wr !== 0 || s_ready !== 1 || pend1 !== 0 || pend2 !== 0) begin n_bad++; $display("FAIL midreset got wr%b rdy%b p%b%b want 0100", wr, s_ready, pend1, pend2); end
    m_q.delete(); e_wr = 0; e_a = 0; e_d = 0;
    @(posedge clk); @(negedge clk); reset = 1;
    @(posedge clk); #1;
    idle(6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      p_wr = ($urandom_range(0, 9) < 4); p_addr = $urandom_range(0, 7); p_data = $urandom;
      s_valid = ($urandom_range(0, 9) < 6); s_addr = $urandom_range(0, 7); s_data = $urandom;
      rd_addr1 = $urandom_range(0, 7); rd_addr2 = $urandom_range(0, 7);
      rf_data1 = $urandom; rf_data2 = $urandom;
      cycle();
    end
    idle(8);
  endtask

  initial begin
    foreach (rf[i]) rf[i] = 0;
    test_reset();
    test_secondary();
    test_priority_full();
    test_kill();
    test_zero();
    test_fwd();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
